// File: rtl/cordic_arbiter_if.sv
// Requester, core and response bundle for the shared CORDIC arbiter.
// slave = arbiter side, master = clients plus core side.
interface cordic_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 16
);
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*WIDTH-1:0] req_x;
   logic [N*WIDTH-1:0] req_y;
   logic [N*WIDTH-1:0] req_z;
   logic [WIDTH-1:0]   cordic_x0;
   logic [WIDTH-1:0]   cordic_y0;
   logic [WIDTH-1:0]   cordic_z0;
   logic [WIDTH-1:0]   cordic_x;
   logic [WIDTH-1:0]   cordic_y;
   logic [WIDTH-1:0]   cordic_z;
   logic [N-1:0]       resp_valid;
   logic [WIDTH-1:0]   resp_x;
   logic [WIDTH-1:0]   resp_y;
   logic [WIDTH-1:0]   resp_z;
   logic               busy;

   modport slave (
      input  req_valid, req_x, req_y, req_z,
      input  cordic_x, cordic_y, cordic_z,
      output req_ready,
      output cordic_x0, cordic_y0, cordic_z0,
      output resp_valid, resp_x, resp_y, resp_z,
      output busy
   );

   modport master (
      output req_valid, req_x, req_y, req_z,
      output cordic_x, cordic_y, cordic_z,
      input  req_ready,
      input  cordic_x0, cordic_y0, cordic_z0,
      input  resp_valid, resp_x, resp_y, resp_z,
      input  busy
   );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one pipelined CORDIC core among N requesters.
// A tag pipeline matched to the core latency steers each result home.
module cordic_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 16,
   parameter int LATENCY = 18
) (
   input logic              clk,
   input logic              reset_n,
   input logic              enable,
   cordic_arbiter_if.slave  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef struct packed {
      logic          valid;
      logic [IW-1:0] id;
   } tag_t;

   tag_t             tag_q [LATENCY+1];
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    winner;
   logic [IW-1:0]    ptr_nxt;
   logic             found;
   logic             accept;
   logic [WIDTH-1:0] x0_q;
   logic [WIDTH-1:0] y0_q;
   logic [WIDTH-1:0] z0_q;

   // Scan downward so the lowest offset from the pointer wins last.
   always_comb begin
      logic [IW-1:0] idx;
      idx    = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr_q) + k) % N);
         if (bus.req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign accept  = enable & found;
   assign ptr_nxt = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      bus.req_ready = '0;
      if (accept)
         bus.req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
         x0_q  <= '0;
         y0_q  <= '0;
         z0_q  <= '0;
         for (int k = 0; k <= LATENCY; k++)
            tag_q[k] <= '0;
      end else begin
         tag_q[0].valid <= accept;
         tag_q[0].id    <= winner;
         for (int k = 1; k <= LATENCY; k++)
            tag_q[k] <= tag_q[k-1];
         if (accept) begin
            x0_q  <= bus.req_x[winner*WIDTH +: WIDTH];
            y0_q  <= bus.req_y[winner*WIDTH +: WIDTH];
            z0_q  <= bus.req_z[winner*WIDTH +: WIDTH];
            ptr_q <= ptr_nxt;
         end
      end
   end

   assign bus.cordic_x0 = x0_q;
   assign bus.cordic_y0 = y0_q;
   assign bus.cordic_z0 = z0_q;

   always_comb begin
      bus.busy = 1'b0;
      for (int k = 0; k <= LATENCY; k++)
         bus.busy = bus.busy | tag_q[k].valid;
   end

   always_comb begin
      bus.resp_valid = '0;
      if (tag_q[LATENCY].valid)
         bus.resp_valid[tag_q[LATENCY].id] = 1'b1;
   end

   assign bus.resp_x = bus.cordic_x;
   assign bus.resp_y = bus.cordic_y;
   assign bus.resp_z = bus.cordic_z;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Random-stimulus bench for cordic_arbiter with a stand-in core and a
// queue-based reference of grants, responses and busy.
module tb_cordic_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 18;

   typedef struct {
      int           due;
      int           id;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
   } op_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;

   cordic_arbiter_if #(.N(N), .WIDTH(W)) bus ();

   cordic_arbiter #(.N(N), .WIDTH(W), .LATENCY(L)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Stand-in core: an arbitrary data transform, no reset.
   function automatic logic [3*W-1:0] core_f(
      input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
      return {x ^ W'(16'h5a5a), y + z, z - W'(1)};
   endfunction

   logic [3*W-1:0] core_q [L];
   always @(posedge clk) begin
      core_q[0] <= core_f(bus.cordic_x0, bus.cordic_y0, bus.cordic_z0);
      for (int k = 1; k < L; k++)
         core_q[k] <= core_q[k-1];
   end
   assign {bus.cordic_x, bus.cordic_y, bus.cordic_z} = core_q[L-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   bit           pend [N];
   logic [W-1:0] px [N];
   logic [W-1:0] py [N];
   logic [W-1:0] pz [N];
   op_t          sb [$];
   int           ptr = 0;
   int           cyc = 0;
   logic [W-1:0] mx0 = '0;
   logic [W-1:0] my0 = '0;
   logic [W-1:0] mz0 = '0;
   logic [W-1:0] zctr = '0;

   task automatic step(input logic [N-1:0] mask, input int prob,
                       input int en_pct, input bit zinc, input bit rst);
      int             win;
      logic [N-1:0]   exp_rdy;
      logic [N-1:0]   exp_rv;
      logic [3*W-1:0] r;
      bit             due;
      op_t            op;
      @(negedge clk);
      reset_n = !rst;
      if (rst) begin
         sb.delete();
         ptr = 0;
         mx0 = '0;
         my0 = '0;
         mz0 = '0;
      end
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && mask[i] && $urandom_range(99) < prob) begin
            pend[i] = 1'b1;
            px[i] = W'($urandom);
            py[i] = W'($urandom);
            pz[i] = zinc ? zctr : W'($urandom);
            if (zinc) zctr = zctr + W'(1);
         end
         bus.req_valid[i] = pend[i];
         bus.req_x[i*W +: W] = px[i];
         bus.req_y[i*W +: W] = py[i];
         bus.req_z[i*W +: W] = pz[i];
      end
      enable = !rst && ($urandom_range(99) < en_pct);
      #1;
      win = -1;
      for (int k = 0; k < N; k++)
         if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
      exp_rdy = (enable && win >= 0) ? N'(1 << win) : '0;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("cordic_x0", 64'(bus.cordic_x0), 64'(mx0));
      check("cordic_y0", 64'(bus.cordic_y0), 64'(my0));
      check("cordic_z0", 64'(bus.cordic_z0), 64'(mz0));
      check("busy", 64'(bus.busy), 64'(sb.size() > 0));
      due = sb.size() > 0 && sb[0].due == cyc;
      exp_rv = due ? N'(1 << sb[0].id) : '0;
      check("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
      if (due) begin
         check("resp_x", 64'(bus.resp_x), 64'(sb[0].x));
         check("resp_y", 64'(bus.resp_y), 64'(sb[0].y));
         check("resp_z", 64'(bus.resp_z), 64'(sb[0].z));
         void'(sb.pop_front());
      end
      if (exp_rdy != '0) begin
         r = core_f(px[win], py[win], pz[win]);
         op.due = cyc + 1 + L;
         op.id = win;
         {op.x, op.y, op.z} = r;
         sb.push_back(op);
         mx0 = px[win];
         my0 = py[win];
         mz0 = pz[win];
         pend[win] = 1'b0;
         ptr = (win + 1) % N;
      end
      cyc++;
   endtask

   task automatic run(input int n, input logic [N-1:0] mask, input int prob,
                      input int en_pct, input bit zinc);
      for (int c = 0; c < n; c++)
         step(mask, prob, en_pct, zinc, 1'b0);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.req_z = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         px[i] = '0;
         py[i] = '0;
         pz[i] = '0;
      end
      repeat (3) @(posedge clk);
      // Single op from requester 2.
      run(2, 4'b0000, 0, 100, 1'b0);
      pend[2] = 1'b1;
      px[2] = W'(19898);
      py[2] = W'(0);
      pz[2] = W'(8192);
      run(L + 4, 4'b0000, 0, 100, 1'b0);
      // Fairness from pointer 0.
      step(4'b0000, 0, 100, 1'b0, 1'b1);
      run(8, 4'b1111, 100, 100, 1'b0);
      run(L + 6, 4'b0000, 0, 100, 1'b0);
      // Sparse with wrap.
      run(6, 4'b1010, 100, 100, 1'b0);
      run(L + 4, 4'b0000, 0, 100, 1'b0);
      // Enable gating, then 3 accepts and drain.
      run(5, 4'b1111, 100, 0, 1'b0);
      run(3, 4'b1111, 100, 100, 1'b0);
      run(L + 4, 4'b1111, 100, 0, 1'b0);
      // Reset mid-flight.
      run(5, 4'b1111, 100, 100, 1'b0);
      step(4'b0000, 0, 0, 1'b0, 1'b1);
      run(2 * L, 4'b0000, 0, 0, 1'b0);
      run(L + 6, 4'b0000, 0, 100, 1'b0);
      // Back-to-back requester 0 with incrementing z0.
      run(20, 4'b0001, 100, 100, 1'b1);
      run(L + 4, 4'b0000, 0, 100, 1'b0);
      // Random traffic with occasional resets.
      for (int b = 0; b < 8; b++) begin
         run(80, 4'b1111, 45, 85, 1'b0);
         if (b == 3) step(4'b0000, 0, 0, 1'b0, 1'b1);
      end
      run(L + 8, 4'b0000, 0, 100, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Round-robin scheduler that shares one pipelined rotation-mode CORDIC core among N requesters. It accepts at most one request per cycle, drives the core's registered inputs, and carries a requester tag down a shift pipeline matched to the core latency. Each result is steered back to the requester that issued it. It sits between client blocks (NCOs, mixers, polar converters) and a single `cordic` instance.

Parameters:
N, 4, number of requesters (≥2)
WIDTH, 16, data width of x/y/z; must equal the core's width
LATENCY, 18, core latency in clock edges from input sample to output register (= core iterations + 1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active low
enable  input  1  1 = grants allowed; 0 = no new grants, in-flight ops drain
req_valid  input  N  per-requester request valid
req_ready  output  N  per-requester accept, one-hot or zero
req_x  input  N*WIDTH  packed x0 operands, requester i at bits [i*WIDTH +: WIDTH]
req_y  input  N*WIDTH  packed y0 operands
req_z  input  N*WIDTH  packed z0 angles (π = 2**(WIDTH-1))
cordic_x0, cordic_y0, cordic_z0  output  WIDTH each  registered operands to the core
cordic_x, cordic_y, cordic_z  input  WIDTH each  core outputs
resp_valid  output  N  one-hot result strobe, one cycle
resp_x, resp_y, resp_z  output  WIDTH each  shared result bus (pass-through of cordic_x/y/z)
busy  output  1  1 while any operation is in flight

Behaviour:
- Reset is asynchronous and active low (reset_n); clk is the only clock.
- Reset values:
  - cordic_x0/y0/z0 = 0; resp_valid = 0; busy = 0.
  - Round-robin pointer = 0.
  - All tag stages: valid = 0, id = 0.
- Arbitration (combinational):
  - Search req_valid starting at the pointer, ascending with wrap modulo N; the first set bit wins.
  - req_ready[i] = enable & (i == winner).
  - No valid request or enable = 0 → req_ready = 0.
  - req_ready may depend on req_valid. A requester must hold req_valid and its data stable until accepted.
- Accept edge E0 (req_valid[i] & req_ready[i]):
  - cordic_x0/y0/z0 <= req_x/y/z slice i.
  - tag[0] <= {valid = 1, id = i}.
  - pointer <= (i+1) mod N.
- No accept:
  - tag[0].valid <= 0; cordic_x0/y0/z0 and pointer hold.
- Tag pipeline: LATENCY+1 stages. tag[k] <= tag[k-1] every edge with no stall, so tag[k] is loaded at E0+k.
  - The core samples cordic_x0 at E0+1 and updates its outputs at E0+LATENCY.
  - tag[LATENCY] therefore aligns with cordic_x/y/z.
- Response:
  - resp_valid[j] = tag[LATENCY].valid & (tag[LATENCY].id == j).
  - resp_x/y/z = cordic_x/y/z (combinational).
  - The response is visible in the cycle after edge E0+LATENCY.
  - No backpressure: requesters must take the response in that cycle.
- Throughput: one accept per cycle sustained. A lone requester asserting valid continuously is accepted every cycle.
- busy = OR of tag[0..LATENCY].valid.
- enable falling mid-stream: no new accepts; in-flight ops complete normally; busy drops after the last response.
- Reset mid-operation: all tags cleared immediately, so no response is emitted for dropped operations, even if the core itself is not reset.
- The arbiter never modifies data; quadrant handling and rounding belong to the core.
- id width = $clog2(N).

Test Plan:
- Single op: requester 2 sends x0=19898, y0=0, z0=8192 (π/4), enable=1 → req_ready=4'b0100 that cycle; resp_valid=4'b0100 exactly LATENCY+1 cycles later with resp_x≈resp_y≈32768·cos45°·K-scaled value matching a standalone core; busy high throughout, then low.
- Fairness: all four req_valid held high for 8 cycles from pointer 0 → grants 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle, with correct ids.
- Sparse/wrap: pointer at 3, only req_valid[1] and req_valid[3] high → grants 3 then 1 then 3; req_ready never asserted for idle requesters.
- Enable gating: enable=0 with all valid high → req_ready=0 and no tags issued. Drop enable after 3 accepts → exactly 3 responses arrive, then busy=0.
- Reset mid-flight: issue 5 ops, assert reset_n=0 for 1 cycle after the 10th edge → resp_valid stays 0 for the next 2·LATENCY cycles; busy=0; pointer=0.
- Back-to-back same requester: only req_valid[0] high for 20 cycles with incrementing z0 → 20 accepts, 20 consecutive resp_valid[0] pulses, results in issue order.
